// File: rtl/alu_issue_scheduler.sv
// Two-requester round-robin issue front-end for the shared 32-bit ALU. It holds the
// ALU inputs for a per-op latency. Optional ALU_SCHED_ILLEGAL_TRAP_EN traps op >= 14.
module alu_issue_scheduler #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_sel,
  input  logic [63:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [3:0] MUL_M1 = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_M1 = 4'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [4:0]  alu_sel_q, alu_sel_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_err_q, rsp_err_d;
  logic        illegal_q, illegal_d;

  logic        grant0, grant1, accept;
  logic        acc_id;
  logic [4:0]  acc_op;
  logic [31:0] acc_a, acc_b;
  logic        acc_illegal;
  logic [3:0]  acc_lat_m1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_err_q  <= rsp_err_d;
      illegal_q  <= illegal_d;
    end
  end

  // Round-robin grant: on a tie the requester not granted last wins
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_q);
    grant1 = req1_valid & (~req0_valid | ~last_q);
    acc_id = grant1;
    acc_op = grant1 ? req1_op : req0_op;
    acc_a  = grant1 ? req1_a  : req0_a;
    acc_b  = grant1 ? req1_b  : req0_b;
`ifdef ALU_SCHED_ILLEGAL_TRAP_EN
    acc_illegal = (acc_op >= 5'd14);
`else
    acc_illegal = 1'b0;
`endif
    case (acc_op)
      5'd2:    acc_lat_m1 = MUL_M1;
      5'd3:    acc_lat_m1 = DIV_M1;
      default: acc_lat_m1 = '0;
    endcase
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_err_d  = rsp_err_q;
    illegal_d  = illegal_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          alu_a_d   = acc_a;
          alu_b_d   = acc_b;
          if (!acc_illegal) alu_sel_d = acc_op;
          rsp_id_d  = acc_id;
          last_d    = acc_id;
          illegal_d = acc_illegal;
          cnt_d     = acc_lat_m1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_data_d = illegal_q ? '0 : alu_out;
          rsp_err_d  = illegal_q;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req0_ready = (state_q == IDLE) & grant0;
    req1_ready = (state_q == IDLE) & grant1;
    accept     = req0_ready | req1_ready;
    rsp_valid  = (state_q == RESP);
    busy       = (state_q != IDLE);
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    alu_sel    = alu_sel_q;
    rsp_data   = rsp_data_q;
    rsp_id     = rsp_id_q;
    rsp_err    = rsp_err_q;
  end

endmodule
